// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
//  instr_fetch_unit_if : fetch-stage bus (imem handshake + decode/retire side)
//  Revision 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  OP;
    logic [5:0]  Funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ack;
    logic        Jump;
    logic        Branch;
    logic        Zero;

    modport master (
        output imem_req, imem_addr, instr, OP, Funct, pc, pc_plus4, instr_valid,
        input  imem_ready, imem_rdata, instr_ack, Jump, Branch, Zero
    );

    modport slave (
        input  imem_req, imem_addr, instr, OP, Funct, pc, pc_plus4, instr_valid,
        output imem_ready, imem_rdata, instr_ack, Jump, Branch, Zero
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
//  instr_fetch_unit : PC + one-word fetch, holds instr until retire, next-PC calc
//  Optional feature macro: IF_STALL_COUNT_EN (imem wait-cycle counter)
//  Revision 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic           clk,
    input  wire logic           reset,
    instr_fetch_unit_if.master  bus
`ifdef IF_STALL_COUNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_w;
    logic [31:0] br_off_w;
    logic [31:0] next_pc_w;

    assign pc_plus4_w = pc_q + 32'd4;
    assign br_off_w   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump has priority over a taken branch
    always_comb begin
        next_pc_w = pc_plus4_w;
        if (bus.Jump) begin
            next_pc_w = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
        end else if (bus.Branch && bus.Zero) begin
            next_pc_w = pc_plus4_w + br_off_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (bus.instr_ack) begin
                    pc_d    = next_pc_w;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.imem_req    = (state_q == REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == VALID);
    assign bus.instr       = instr_q;
    assign bus.OP          = instr_q[31:26];
    assign bus.Funct       = instr_q[5:0];
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4_w;

`ifdef IF_STALL_COUNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 32'h0000_0000;
        end else if ((state_q == REQ) && !bus.imem_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
//  tb_instr_fetch_unit : directed self-checking bench for instr_fetch_unit
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    instr_fetch_unit_if bus ();

`ifdef IF_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef IF_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    // Wait (bounded) for a request, then answer it with a zero-wait response.
    task automatic serve(input logic [31:0] word);
        int k;
        k = 0;
        while (bus.imem_req !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus.imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL serve_timeout imem_req=%b required=1", bus.imem_req);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    task automatic retire(input logic j, input logic b, input logic z);
        bus.instr_ack = 1'b1;
        bus.Jump      = j;
        bus.Branch    = b;
        bus.Zero      = z;
        @(negedge clk);
        bus.instr_ack = 1'b0;
        bus.Jump      = 1'b0;
        bus.Branch    = 1'b0;
        bus.Zero      = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
        n_cmp++; if (bus.pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got=%h exp=00000000", bus.pc); end
        n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got=%h exp=00000000", bus.instr); end
`ifdef IF_STALL_COUNT_EN
        n_cmp++; if (stall_cycles !== 32'h0) begin n_err++; $display("FAIL rst_stall got=%0d exp=0", stall_cycles); end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_fetch;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL ff_req got=%b exp=1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL ff_addr got=%h exp=00000000", bus.imem_addr); end
        serve(32'h2008_0005);
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL ff_valid got=%b exp=1", bus.instr_valid); end
        n_cmp++; if (bus.OP !== 6'h08) begin n_err++; $display("FAIL ff_op got=%h exp=08", bus.OP); end
        n_cmp++; if (bus.Funct !== 6'h05) begin n_err++; $display("FAIL ff_funct got=%h exp=05", bus.Funct); end
        n_cmp++; if (bus.instr !== 32'h2008_0005) begin n_err++; $display("FAIL ff_instr got=%h exp=20080005", bus.instr); end
        n_cmp++; if (bus.pc !== 32'h0) begin n_err++; $display("FAIL ff_pc got=%h exp=00000000", bus.pc); end
        n_cmp++; if (bus.pc_plus4 !== 32'h4) begin n_err++; $display("FAIL ff_pc4 got=%h exp=00000004", bus.pc_plus4); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL ff_req_valid got=%b exp=0", bus.imem_req); end
    endtask

    task automatic test_sequential;
        retire(1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL seq_req got=%b exp=1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h4) begin n_err++; $display("FAIL seq_addr got=%h exp=00000004", bus.imem_addr); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_valid got=%b exp=0", bus.instr_valid); end
    endtask

    task automatic test_branch;
        serve(32'h0800_0004);          // j 0x10
        retire(1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.imem_addr !== 32'h10) begin n_err++; $display("FAIL br_jmp_addr got=%h exp=00000010", bus.imem_addr); end
        serve(32'h1109_FFFC);          // beq, imm -4
        retire(1'b0, 1'b1, 1'b1);
        n_cmp++; if (bus.imem_addr !== 32'h04) begin n_err++; $display("FAIL br_taken_addr got=%h exp=00000004", bus.imem_addr); end
        serve(32'h0800_0004);
        retire(1'b1, 1'b0, 1'b0);
        serve(32'h1109_FFFC);
        retire(1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.imem_addr !== 32'h14) begin n_err++; $display("FAIL br_not_taken_addr got=%h exp=00000014", bus.imem_addr); end
        serve(32'h1109_FFFC);          // Zero without Branch: sequential
        retire(1'b0, 1'b0, 1'b1);
        n_cmp++; if (bus.imem_addr !== 32'h18) begin n_err++; $display("FAIL br_zero_only_addr got=%h exp=00000018", bus.imem_addr); end
    endtask

    task automatic test_jump_priority;
        serve(32'h0810_0002);          // j 0x00400008
        retire(1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.imem_addr !== 32'h0040_0008) begin n_err++; $display("FAIL jp_setup_addr got=%h exp=00400008", bus.imem_addr); end
        serve(32'h0810_0010);
        n_cmp++; if (bus.pc_plus4 !== 32'h0040_000C) begin n_err++; $display("FAIL jp_pc4 got=%h exp=0040000c", bus.pc_plus4); end
        retire(1'b1, 1'b1, 1'b1);
        n_cmp++; if (bus.imem_addr !== 32'h0040_0040) begin n_err++; $display("FAIL jp_addr got=%h exp=00400040", bus.imem_addr); end
    endtask

    task automatic test_wrap;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        serve(32'h1000_FFFE);          // beq, imm -2: 4 - 8 wraps
        retire(1'b0, 1'b1, 1'b1);
        n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_br_addr got=%h exp=fffffffc", bus.imem_addr); end
        serve(32'h0000_0000);
        n_cmp++; if (bus.pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got=%h exp=00000000", bus.pc_plus4); end
        retire(1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got=%h exp=00000000", bus.imem_addr); end
    endtask

    task automatic test_ignored;
        bus.instr_ack = 1'b1;
        bus.Jump      = 1'b1;
        @(negedge clk);
        bus.instr_ack = 1'b0;
        bus.Jump      = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL ign_ack_req got=%b exp=1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL ign_ack_addr got=%h exp=00000000", bus.imem_addr); end
        serve(32'h2008_0005);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        n_cmp++; if (bus.instr !== 32'h2008_0005) begin n_err++; $display("FAIL ign_rdy_instr got=%h exp=20080005", bus.instr); end
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL ign_rdy_valid got=%b exp=1", bus.instr_valid); end
        retire(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL stall_req[%0d] got=%b exp=1", i, bus.imem_req); end
            n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL stall_addr[%0d] got=%h exp=00000000", i, bus.imem_addr); end
            n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid[%0d] got=%b exp=0", i, bus.instr_valid); end
        end
`ifdef IF_STALL_COUNT_EN
        n_cmp++; if (stall_cycles !== 32'd3) begin n_err++; $display("FAIL stall_count got=%0d exp=3", stall_cycles); end
`endif
    endtask

    task automatic test_reset_mid_fetch;
        serve(32'h2008_0005);
        retire(1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.imem_addr !== 32'h4) begin n_err++; $display("FAIL rmr_setup_addr got=%h exp=00000004", bus.imem_addr); end
        reset = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        n_cmp++; if (bus.pc !== 32'h0) begin n_err++; $display("FAIL rmr_pc got=%h exp=00000000", bus.pc); end
        n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL rmr_instr got=%h exp=00000000", bus.instr); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rmr_valid got=%b exp=0", bus.instr_valid); end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rmr_req got=%b exp=1", bus.imem_req); end
        @(negedge clk);
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rmr_valid2 got=%b exp=0", bus.instr_valid); end
        // reset while an instruction awaits retire
        serve(32'h2008_0005);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rmv_valid got=%b exp=0", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL rmv_instr got=%h exp=00000000", bus.instr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ack  = 1'b0;
        bus.Jump       = 1'b0;
        bus.Branch     = 1'b0;
        bus.Zero       = 1'b0;

        test_reset;
        test_first_fetch;
        test_sequential;
        test_branch;
        test_jump_priority;
        test_wrap;
        test_ignored;
        test_stall;
        test_reset_mid_fetch;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
